button_event_fsm: RTL and testbench



---
 rtl/button_event_fsm.sv | 142 ++++++++++++++
 tb/tb_button_event_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_fsm.sv
// Classifies debounced button gestures as short press, long press or double click.
// Define BTN_DCLICK_EN to build the double-click path (GAP/PRESS2 states).
module button_event_fsm #(
  parameter int LONG_CYC   = 25000000,
  parameter int DCLICK_CYC = 15000000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db_level,
  input  logic       db_tick,
  output logic       short_tick,
  output logic       long_tick,
  output logic       double_tick,
  output logic       held,
  output logic       busy,
  output logic [1:0] last_evt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lvl_d;
  logic             rel;

  // A release is seen in the first cycle the debounced level reads low.
  assign rel = lvl_d & ~db_level;

`ifdef BTN_DCLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
  logic dbl_q;
  assign double_tick = dbl_q;
`else
  logic unused_dclick;
  assign unused_dclick = (DCLICK_CYC != 0);
  assign double_tick   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lvl_d      <= 1'b0;
      short_tick <= 1'b0;
      long_tick  <= 1'b0;
      held       <= 1'b0;
      busy       <= 1'b0;
      last_evt   <= 2'b00;
`ifdef BTN_DCLICK_EN
      dbl_q      <= 1'b0;
`endif
    end else begin
      lvl_d      <= db_level;
      short_tick <= 1'b0;
      long_tick  <= 1'b0;
`ifdef BTN_DCLICK_EN
      dbl_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (db_tick) begin
            state <= PRESS1;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Release outranks the long threshold when both land in one cycle.
        PRESS1: begin
          if (rel) begin
`ifdef BTN_DCLICK_EN
            state <= GAP;
            cnt   <= '0;
`else
            state      <= IDLE;
            busy       <= 1'b0;
            short_tick <= 1'b1;
            last_evt   <= 2'b01;
`endif
          end else if (cnt == LONG_LAST) begin
            state     <= LONG;
            held      <= 1'b1;
            long_tick <= 1'b1;
            last_evt  <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LONG: begin
          if (rel) begin
            state <= IDLE;
            held  <= 1'b0;
            busy  <= 1'b0;
          end
        end

`ifdef BTN_DCLICK_EN
        // A second press wins over the gap timeout in the same cycle.
        GAP: begin
          if (db_tick) begin
            state    <= PRESS2;
            dbl_q    <= 1'b1;
            last_evt <= 2'b11;
          end else if (cnt == DCLICK_LAST) begin
            state      <= IDLE;
            busy       <= 1'b0;
            short_tick <= 1'b1;
            last_evt   <= 2'b01;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESS2: begin
          if (rel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif

        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Scoreboard bench for button_event_fsm; expected ticks are queued with their due cycle.
// Follows BTN_DCLICK_EN the same way the design does.
module tb_button_event_fsm;

  localparam int LONG_CYC   = 20;
  localparam int DCLICK_CYC = 10;
  localparam int CNT_W      = 5;

  localparam logic [2:0] EV_SHORT = 3'b100;
  localparam logic [2:0] EV_LONG  = 3'b010;
  localparam logic [2:0] EV_DBL   = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       db_level = 1'b1;
  logic       db_tick = 1'b0;
  logic       short_tick, long_tick, double_tick, held, busy;
  logic [1:0] last_evt;

  typedef struct {
    int         cyc;
    logic [2:0] ticks;
    logic [1:0] evt;
  } sb_item_t;

  sb_item_t sb[$];
  int       cyc = 0;
  int       vectors = 0;
  int       miscompares = 0;
  bit       mon_en = 1'b0;

  button_event_fsm #(
    .LONG_CYC  (LONG_CYC),
    .DCLICK_CYC(DCLICK_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .db_level   (db_level),
    .db_tick    (db_tick),
    .short_tick (short_tick),
    .long_tick  (long_tick),
    .double_tick(double_tick),
    .held       (held),
    .busy       (busy),
    .last_evt   (last_evt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic level, input logic tick);
    @(posedge clk);
    #1;
    db_level = level;
    db_tick  = tick;
  endtask

  task automatic expectEvent(input int at, input logic [2:0] ticks, input logic [1:0] evt);
    sb.push_back('{cyc: at, ticks: ticks, evt: evt});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0);
  endtask

  // Tick with level low, hold level high for 'hold' cycles, then the first low cycle.
  task automatic press(input int hold, output int rel_cyc);
    applyStimulus(1'b0, 1'b1);
    repeat (hold) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    rel_cyc = cyc;
  endtask

  function automatic int shortAt(input int rel_cyc);
`ifdef BTN_DCLICK_EN
    return rel_cyc + DCLICK_CYC + 1;
`else
    return rel_cyc + 1;
`endif
  endfunction

  task automatic singlePress(input int hold);
    int r;
    press(hold, r);
    expectEvent(shortAt(r), EV_SHORT, 2'b01);
    idle(15);
    checkOutput("busy_after_short", 32'(busy), 32'd0);
  endtask

  // Second tick lands 'gap' cycles after the first release.
  task automatic twoPresses(input int gap);
    int  r1, r2;
    bit  is_dbl;
    press(5, r1);
`ifdef BTN_DCLICK_EN
    is_dbl = (gap <= DCLICK_CYC);
`else
    is_dbl = 1'b0;
`endif
    if (is_dbl) expectEvent(r1 + gap + 1, EV_DBL, 2'b11);
    else        expectEvent(shortAt(r1), EV_SHORT, 2'b01);
    repeat (gap - 1) applyStimulus(1'b0, 1'b0);
    press(5, r2);
    if (!is_dbl) expectEvent(shortAt(r2), EV_SHORT, 2'b01);
    idle(15);
    checkOutput("busy_after_pair", 32'(busy), 32'd0);
    checkOutput("last_evt_pair", 32'(last_evt), is_dbl ? 32'd3 : 32'd1);
  endtask

  always @(negedge clk) begin : monitor
    sb_item_t   it;
    logic [2:0] exp_t;
    if (mon_en) begin
      exp_t = 3'b000;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        it    = sb.pop_front();
        exp_t = it.ticks;
        checkOutput("last_evt_at_tick", 32'(last_evt), 32'(it.evt));
      end
      checkOutput("ticks", 32'({short_tick, long_tick, double_tick}), 32'(exp_t));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] bench timed out");
  end

  initial begin
    int t0, r;
    reset    = 1'b1;
    db_level = 1'b1;
    applyStimulus(1'b1, 1'b0);
    mon_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_outputs",
                32'({short_tick, long_tick, double_tick, held, busy, last_evt}), 32'd0);
    reset = 1'b0;
    repeat (4) applyStimulus(1'b1, 1'b0);
    idle(5);
    checkOutput("busy_after_reset_release", 32'(busy), 32'd0);

    singlePress(5);

    applyStimulus(1'b0, 1'b1);
    t0 = cyc;
    expectEvent(t0 + LONG_CYC + 1, EV_LONG, 2'b10);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (cyc == t0 + 1)            checkOutput("busy_on_press", 32'(busy), 32'd1);
      if (cyc == t0 + LONG_CYC)     checkOutput("held_before_long", 32'(held), 32'd0);
      if (cyc == t0 + LONG_CYC + 1) checkOutput("held_at_long", 32'(held), 32'd1);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("held_release_cycle", 32'(held), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("held_after_release", 32'(held), 32'd0);
    checkOutput("busy_after_long", 32'(busy), 32'd0);
    idle(15);
    checkOutput("last_evt_long", 32'(last_evt), 32'd2);

    // Reset in the middle of a press; the later release must be ignored.
    applyStimulus(1'b0, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("busy_in_reset", 32'(busy), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
    repeat (25) applyStimulus(1'b1, 1'b0);
    checkOutput("busy_held_after_reset", 32'(busy), 32'd0);
    idle(15);
    checkOutput("last_evt_cleared", 32'(last_evt), 32'd0);

    twoPresses(4);
    twoPresses(11);

    press(LONG_CYC - 1, r);
    expectEvent(shortAt(r), EV_SHORT, 2'b01);
    idle(15);
    checkOutput("last_evt_edge_release", 32'(last_evt), 32'd1);

    twoPresses(DCLICK_CYC);

    idle(5);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
